// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control unit.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECUTE,
        ALUWB,
        BRANCH,
        ADDIEX,
        ADDIWB,
        JUMP
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes
    localparam logic [5:0] FN_NOP = 6'b000000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUOp from main FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU source B select
    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// ALU-control decoder: maps ALUOp and the R-type funct field to the ALU
// control code, flagging funct values the core does not implement.
module mips_alu_decoder
    import mips_mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctl,
    output logic       funct_illegal
);

    // Decode ALUOp, falling through to the funct table for R-type execution
    always_comb begin
        alu_ctl       = ALU_ADD;
        funct_illegal = 1'b0;
        case (alu_op)
            ALUOP_SUB: alu_ctl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_ctl = ALU_ADD;
                    FN_SUB:  alu_ctl = ALU_SUB;
                    FN_AND:  alu_ctl = ALU_AND;
                    FN_OR:   alu_ctl = ALU_OR;
                    FN_SLT:  alu_ctl = ALU_SLT;
                    FN_NOP:  alu_ctl = ALU_ADD;  // nop/sll: no write-back follows
                    default: funct_illegal = 1'b1;
                endcase
            end
            default: alu_ctl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Main control FSM for the multi-cycle MIPS core (Moore, 3-5 cycles/instr).
// Optional build macro MIPS_MC_MEM_WAIT_EN adds MEM_READY so FETCH, MEMRD
// and MEMWR stall until the unified memory is ready.
module mips_mc_control
    import mips_mc_pkg::*;
#(
    parameter int OP_W     = 6,
    parameter int ALUCTL_W = 3
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic [OP_W-1:0]     OPCODE,
    input  logic [OP_W-1:0]     FUNCT,
    input  logic                ZERO,
`ifdef MIPS_MC_MEM_WAIT_EN
    input  logic                MEM_READY,
`endif
    output logic                IORD,
    output logic                MEM_WRITE,
    output logic                IR_WRITE,
    output logic                PC_EN,
    output logic                REG_DST,
    output logic                MEM_TO_REG,
    output logic                REG_WRITE,
    output logic                ALU_SRC_A,
    output logic [1:0]          ALU_SRC_B,
    output logic [1:0]          PC_SRC,
    output logic [ALUCTL_W-1:0] ALU_CTL,
    output logic                ILLEGAL
);

    state_t state_q, state_d;

    logic       mem_ready;
    logic       iord_c, mem_write_c, ir_write_c, pc_en_c;
    logic       reg_dst_c, mem_to_reg_c, reg_write_c, src_a_c;
    logic [1:0] src_b_c, pc_src_c, alu_op_c;
    logic       alu_en_c, illegal_c;
    logic [2:0] dec_alu_ctl;
    logic       dec_funct_illegal;

`ifdef MIPS_MC_MEM_WAIT_EN
    assign mem_ready = MEM_READY;
`else
    assign mem_ready = 1'b1;
`endif

    mips_alu_decoder u_alu_dec (
        .alu_op        (alu_op_c),
        .funct         (FUNCT),
        .alu_ctl       (dec_alu_ctl),
        .funct_illegal (dec_funct_illegal)
    );

    // State register; reset returns to FETCH immediately
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Next-state and Moore outputs; every signal defaults to inactive
    always_comb begin
        state_d      = state_q;
        iord_c       = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        pc_en_c      = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        reg_write_c  = 1'b0;
        src_a_c      = 1'b0;
        src_b_c      = SRCB_REGB;
        pc_src_c     = PCSRC_ALU;
        alu_op_c     = ALUOP_ADD;
        alu_en_c     = 1'b0;
        illegal_c    = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write_c = mem_ready;
                pc_en_c    = mem_ready;
                src_b_c    = SRCB_FOUR;
                alu_en_c   = 1'b1;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                // Branch target is computed speculatively into ALUOut
                src_b_c  = SRCB_IMMSH2;
                alu_en_c = 1'b1;
                case (OPCODE)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                src_a_c  = 1'b1;
                src_b_c  = SRCB_IMM;
                alu_en_c = 1'b1;
                // Only lw/sw reach here, and the IR still holds the opcode
                state_d  = (OPCODE == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord_c = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                state_d      = FETCH;
            end
            MEMWR: begin
                iord_c      = 1'b1;
                mem_write_c = mem_ready;
                if (mem_ready) state_d = FETCH;
            end
            EXECUTE: begin
                src_a_c  = 1'b1;
                alu_op_c = ALUOP_FUNCT;
                alu_en_c = 1'b1;
                if (dec_funct_illegal) begin
                    illegal_c = 1'b1;
                    state_d   = FETCH;
                end else if (FUNCT == FN_NOP) begin
                    state_d = FETCH;
                end else begin
                    state_d = ALUWB;
                end
            end
            ALUWB: begin
                reg_dst_c   = 1'b1;
                reg_write_c = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                src_a_c  = 1'b1;
                alu_op_c = ALUOP_SUB;
                alu_en_c = 1'b1;
                pc_src_c = PCSRC_ALUOUT;
                pc_en_c  = ZERO;
                state_d  = FETCH;
            end
            ADDIEX: begin
                src_a_c  = 1'b1;
                src_b_c  = SRCB_IMM;
                alu_en_c = 1'b1;
                state_d  = ADDIWB;
            end
            ADDIWB: begin
                reg_write_c = 1'b1;
                state_d     = FETCH;
            end
            JUMP: begin
                pc_src_c = PCSRC_JUMP;
                pc_en_c  = 1'b1;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // While reset is asserted every enable and select is held at zero,
    // so nothing is written between RSTn falling and the first FETCH.
    assign IORD       = RSTn & iord_c;
    assign MEM_WRITE  = RSTn & mem_write_c;
    assign IR_WRITE   = RSTn & ir_write_c;
    assign PC_EN      = RSTn & pc_en_c;
    assign REG_DST    = RSTn & reg_dst_c;
    assign MEM_TO_REG = RSTn & mem_to_reg_c;
    assign REG_WRITE  = RSTn & reg_write_c;
    assign ALU_SRC_A  = RSTn & src_a_c;
    assign ALU_SRC_B  = RSTn ? src_b_c : 2'b00;
    assign PC_SRC     = RSTn ? pc_src_c : 2'b00;
    assign ALU_CTL    = (RSTn && alu_en_c) ? dec_alu_ctl : '0;
    assign ILLEGAL    = RSTn & illegal_c;

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: directed instruction table,
// reset/stall corner sequences, and randomized instructions against an
// instruction-level model of the expected per-cycle control outputs.
module tb_mips_mc_control;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic [5:0] OPCODE, FUNCT;
    logic       ZERO;
    logic       IORD, MEM_WRITE, IR_WRITE, PC_EN, REG_DST, MEM_TO_REG;
    logic       REG_WRITE, ALU_SRC_A, ILLEGAL;
    logic [1:0] ALU_SRC_B, PC_SRC;
    logic [2:0] ALU_CTL;
`ifdef MIPS_MC_MEM_WAIT_EN
    logic       MEM_READY = 1'b1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mips_mc_control dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .OPCODE     (OPCODE),
        .FUNCT      (FUNCT),
        .ZERO       (ZERO),
`ifdef MIPS_MC_MEM_WAIT_EN
        .MEM_READY  (MEM_READY),
`endif
        .IORD       (IORD),
        .MEM_WRITE  (MEM_WRITE),
        .IR_WRITE   (IR_WRITE),
        .PC_EN      (PC_EN),
        .REG_DST    (REG_DST),
        .MEM_TO_REG (MEM_TO_REG),
        .REG_WRITE  (REG_WRITE),
        .ALU_SRC_A  (ALU_SRC_A),
        .ALU_SRC_B  (ALU_SRC_B),
        .PC_SRC     (PC_SRC),
        .ALU_CTL    (ALU_CTL),
        .ILLEGAL    (ILLEGAL)
    );

    // Output vector: iord mw irw pce rdst m2r rw srca srcb pcsrc alu ill
    typedef logic [17:0] ov_t;
    typedef struct {
        ov_t v;
        bit  alu_care;
    } exp_t;
    exp_t exp_q[$];

    function automatic ov_t mk(input logic iord, mw, irw, pce, rdst, m2r, rw, sa,
                               input logic [1:0] sb, ps, input logic [2:0] alu,
                               input logic ill);
        return {iord, mw, irw, pce, rdst, m2r, rw, sa, sb, ps, alu, ill};
    endfunction

    function automatic ov_t actual();
        return {IORD, MEM_WRITE, IR_WRITE, PC_EN, REG_DST, MEM_TO_REG, REG_WRITE,
                ALU_SRC_A, ALU_SRC_B, PC_SRC, ALU_CTL, ILLEGAL};
    endfunction

    task automatic check_vec(input string nm, input int cyc, input ov_t e, input bit alu_care);
        ov_t a, m;
        a = actual();
        m = '1;
        if (!alu_care) m[3:1] = 3'b000;
        checks++;
        if ((a & m) !== (e & m)) begin
            errors++;
            $display("FAIL %s cycle %0d got %b expected %b", nm, cyc, a, e);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, want);
        end
    endtask

    // Instruction-level model: list the control word of each cycle
    task automatic build(input logic [5:0] op, fn, input logic z);
        logic [2:0] alu;
        bit known;
        exp_q.delete();
        exp_q.push_back('{mk(0,0,1,1,0,0,0,0,2'b01,2'b00,3'b010,0), 1});
        exp_q.push_back('{mk(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,
                             !(op inside {6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02})), 1});
        case (op)
            6'h23: begin
                exp_q.push_back('{mk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0), 1});
                exp_q.push_back('{mk(1,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,0), 1});
                exp_q.push_back('{mk(0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000,0), 1});
            end
            6'h2b: begin
                exp_q.push_back('{mk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0), 1});
                exp_q.push_back('{mk(1,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0), 1});
            end
            6'h00: begin
                known = 1'b1;
                case (fn)
                    6'h20:   alu = 3'b010;
                    6'h22:   alu = 3'b110;
                    6'h24:   alu = 3'b000;
                    6'h25:   alu = 3'b001;
                    6'h2a:   alu = 3'b111;
                    default: begin alu = 3'b000; known = 1'b0; end
                endcase
                exp_q.push_back('{mk(0,0,0,0,0,0,0,1,2'b00,2'b00,alu, !known && fn != 6'h00), known});
                if (known) exp_q.push_back('{mk(0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,0), 1});
            end
            6'h04: exp_q.push_back('{mk(0,0,0,z,0,0,0,1,2'b00,2'b01,3'b110,0), 1});
            6'h08: begin
                exp_q.push_back('{mk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0), 1});
                exp_q.push_back('{mk(0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000,0), 1});
            end
            6'h02: exp_q.push_back('{mk(0,0,0,1,0,0,0,0,2'b00,2'b10,3'b000,0), 1});
            default: ;
        endcase
    endtask

    // Starts at the beginning of a FETCH cycle, ends at the start of the next
    task automatic run_instr(input string nm, input logic [5:0] op, fn, input logic z);
        OPCODE = op;
        FUNCT  = fn;
        ZERO   = z;
        build(op, fn, z);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge CLK);
            check_vec(nm, i, exp_q[i].v, exp_q[i].alu_care);
            @(posedge CLK);
            #1;
        end
    endtask

    // Counts cycles and strobes until IR_WRITE reappears (bounded)
    task automatic measure(input logic [5:0] op, fn, input logic z,
                           output int cyc, output int rw, output int mw,
                           output int ill, output int pce);
        OPCODE = op;
        FUNCT  = fn;
        ZERO   = z;
        cyc = 0; rw = 0; mw = 0; ill = 0; pce = 0;
        do begin
            @(negedge CLK);
            rw  += int'(REG_WRITE);
            mw  += int'(MEM_WRITE);
            ill += int'(ILLEGAL);
            pce += int'(PC_EN);
            cyc++;
            @(posedge CLK);
            #1;
        end while (IR_WRITE !== 1'b1 && cyc < 12);
    endtask

    typedef struct {
        string       nm;
        logic [31:0] instr;
        logic        z;
        int          cyc, rw, mw, ill, pce;
    } vec_t;
    vec_t tbl[$];

    initial begin
        int cyc, rw, mw, ill, pce;
        logic [31:0] ins;
        logic [5:0]  rop, rfn;
        logic        rz;

        tbl = '{
            '{"addi",    32'h20030080, 1'b0, 4, 1, 0, 0, 1},
            '{"lw",      32'h8C050010, 1'b0, 5, 1, 0, 0, 1},
            '{"sw",      32'hAC040010, 1'b0, 4, 0, 1, 0, 1},
            '{"beq_z1",  32'h10A40003, 1'b1, 3, 0, 0, 0, 2},
            '{"beq_z0",  32'h10640010, 1'b0, 3, 0, 0, 0, 1},
            '{"sub",     32'h00852022, 1'b0, 4, 1, 0, 0, 1},
            '{"add",     32'h00852020, 1'b1, 4, 1, 0, 0, 1},
            '{"and",     32'h00852024, 1'b0, 4, 1, 0, 0, 1},
            '{"or",      32'h00852025, 1'b0, 4, 1, 0, 0, 1},
            '{"slt",     32'h0085202A, 1'b0, 4, 1, 0, 0, 1},
            '{"nop",     32'h00000000, 1'b0, 3, 0, 0, 0, 1},
            '{"bad_fn",  32'h0000003F, 1'b0, 3, 0, 0, 1, 1},
            '{"bad_op",  32'hFC000000, 1'b0, 2, 0, 0, 1, 1},
            '{"j",       32'h08000010, 1'b0, 3, 0, 0, 0, 2}
        };

        RSTn = 1'b0; OPCODE = 6'h00; FUNCT = 6'h00; ZERO = 1'b0;
        #2;
        check_vec("reset_outputs", 0, '0, 1);
        @(posedge CLK); #1;
        check_vec("reset_held", 1, '0, 1);
        RSTn = 1'b1;

        // Directed instructions against the model
        foreach (tbl[k]) begin
            ins = tbl[k].instr;
            run_instr(tbl[k].nm, ins[31:26], ins[5:0], tbl[k].z);
        end

        // Directed instructions against the tabulated cycle/strobe counts
        foreach (tbl[k]) begin
            ins = tbl[k].instr;
            measure(ins[31:26], ins[5:0], tbl[k].z, cyc, rw, mw, ill, pce);
            check_int({tbl[k].nm, "_cycles"}, cyc, tbl[k].cyc);
            check_int({tbl[k].nm, "_regwrite"}, rw, tbl[k].rw);
            check_int({tbl[k].nm, "_memwrite"}, mw, tbl[k].mw);
            check_int({tbl[k].nm, "_illegal"}, ill, tbl[k].ill);
            check_int({tbl[k].nm, "_pc_en"}, pce, tbl[k].pce);
        end

        // Reset asserted in the middle of a store's MEMWR cycle
        OPCODE = 6'h2b; FUNCT = 6'h10; ZERO = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        #3;
        check_vec("sw_memwr_before_reset", 0, mk(1,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0), 1);
        RSTn = 1'b0;
        #1;
        check_vec("sw_reset_immediate", 0, '0, 1);
        @(posedge CLK); #1;
        check_vec("sw_reset_across_edge", 1, '0, 1);
        RSTn = 1'b1;
        #1;
        check_vec("fetch_after_reset", 0, mk(0,0,1,1,0,0,0,0,2'b01,2'b00,3'b010,0), 1);
        run_instr("addi_after_reset", 6'h08, 6'h00, 1'b0);

`ifdef MIPS_MC_MEM_WAIT_EN
        // FETCH stalled for three cycles by memory not ready
        MEM_READY = 1'b0;
        OPCODE = 6'h08;
        for (int s = 0; s < 3; s++) begin
            @(negedge CLK);
            check_vec("fetch_stall", s, mk(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0), 1);
            @(posedge CLK); #1;
        end
        MEM_READY = 1'b1;
        run_instr("addi_after_stall", 6'h08, 6'h00, 1'b0);
`endif

        // Randomized instruction stream
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 7))
                0: rop = 6'h23;
                1: rop = 6'h2b;
                2, 3: rop = 6'h00;
                4: rop = 6'h04;
                5: rop = 6'h08;
                6: rop = 6'h02;
                default: rop = 6'($urandom);
            endcase
            case ($urandom_range(0, 6))
                0: rfn = 6'h20;
                1: rfn = 6'h22;
                2: rfn = 6'h24;
                3: rfn = 6'h25;
                4: rfn = 6'h2a;
                5: rfn = 6'h00;
                default: rfn = 6'($urandom);
            endcase
            rz = 1'($urandom);
            run_instr("random", rop, rfn, rz);
        end

        // The stream must end back in FETCH
        @(negedge CLK);
        check_vec("final_fetch", 0, mk(0,0,1,1,0,0,0,0,2'b01,2'b00,3'b010,0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
